// File: rtl/branch_pkg.sv
// Shared constants and state type for the fetch-redirect branch controller.
package branch_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Resolves a conditional branch in EX from its opcode/rt and the ALU Z/N flags.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic       z,
  input  logic       n,
  output logic       taken
);

  // Condition decode; unknown encodings resolve as not taken.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BLEZ: taken = z | n;
      OP_BGTZ: taken = !z & !n;
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BLTZAL) begin
          taken = n;
        end else if (rt == RT_BGEZ || rt == RT_BGEZAL) begin
          taken = !n;
        end
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flow_controller.sv
// Fetch-redirect controller: picks the PC source each cycle, tracks one
// conditional branch from ID to EX, sequences delay-slot flushes and keeps
// saturating taken / not-taken statistics.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no conditional branch in flight; J/JR redirect from ID
//   PEND  | conditional branch now in EX; ID holds its delay slot
module branch_flow_controller
  import branch_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter bit DS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_branch,
  input  logic [31:0]      id_ta,
  input  logic [31:0]      id_rs_val,
  input  logic [31:0]      ex_ta,
  input  logic [5:0]       ex_opcode,
  input  logic [4:0]       ex_rt,
  input  logic             ex_z,
  input  logic             ex_n,
  input  logic [31:0]      npc,
  output logic [31:0]      pc_next,
  output logic             pc_load_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic             branch_pending,
  output logic             ds_error,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_taken;
  logic             w_resolve;
  logic             w_ds_viol;
  logic             r_ds_error;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_nottaken_cnt;

  branch_cond_eval u_cond (
    .opcode (ex_opcode),
    .rt     (ex_rt),
    .z      (ex_z),
    .n      (ex_n),
    .taken  (w_taken)
  );

  // Branch resolves on the first unstalled PEND cycle; reset suppresses it.
  assign w_resolve = (r_state == PEND) && !stall && !reset;
  assign w_ds_viol = w_resolve && (id_jump || id_jr || id_branch);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and PC-source selection; reset cycle behaves as all defaults.
  always_comb begin
    w_state_nxt    = r_state;
    pc_next        = npc;
    pc_load_target = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    if (!reset && !stall) begin
      case (r_state)
        IDLE: begin
          if (id_jump) begin
            pc_next        = id_ta;
            pc_load_target = 1'b1;
            flush_if       = !DS_EN;
          end else if (id_jr) begin
            pc_next        = id_rs_val;
            pc_load_target = 1'b1;
            flush_if       = !DS_EN;
          end else if (id_branch) begin
            w_state_nxt = PEND;
          end
        end
        PEND: begin
          // Control transfers in the slot are ignored here; only flagged.
          w_state_nxt = IDLE;
          if (w_taken) begin
            pc_next        = ex_ta;
            pc_load_target = 1'b1;
            flush_if       = 1'b1;
            flush_id       = !DS_EN;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign branch_pending = (r_state == PEND);

  // Sticky flag for a control-transfer instruction sitting in a delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ds_error <= 1'b0;
    end else if (w_ds_viol) begin
      r_ds_error <= 1'b1;
    end
  end

  // Saturating resolution statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt    <= '0;
      r_nottaken_cnt <= '0;
    end else if (w_resolve) begin
      if (w_taken) begin
        if (r_taken_cnt != {CNT_W{1'b1}}) begin
          r_taken_cnt <= r_taken_cnt + 1'b1;
        end
      end else begin
        if (r_nottaken_cnt != {CNT_W{1'b1}}) begin
          r_nottaken_cnt <= r_nottaken_cnt + 1'b1;
        end
      end
    end
  end

  assign ds_error     = r_ds_error;
  assign taken_cnt    = r_taken_cnt;
  assign nottaken_cnt = r_nottaken_cnt;

endmodule

// File: tb/tb_branch_flow_controller.sv
// Directed bench: a default instance (DS_EN=1, CNT_W=16) and a squash /
// narrow-counter instance (DS_EN=0, CNT_W=2) share one stimulus stream.
module tb_branch_flow_controller;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        id_jump = 1'b0, id_jr = 1'b0, id_branch = 1'b0;
  logic [31:0] id_ta = '0, id_rs_val = '0, ex_ta = '0, npc = 32'h0040_0008;
  logic [5:0]  ex_opcode = '0;
  logic [4:0]  ex_rt = '0;
  logic        ex_z = 1'b0, ex_n = 1'b0;

  logic [31:0] pc_next, pc_next2;
  logic        ld, ld2, fi, fi2, fid, fid2, pend, pend2, ds, ds2;
  logic [15:0] tk, nt;
  logic [1:0]  tk2, nt2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst, stl, j, jr, br;
    logic [5:0] op;
    logic [4:0] rt;
    logic       z, n;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        ld, fi, fid, pend, ds;
    int          tk, nt;
    logic        chk2, fi2, fid2;
    int          tk2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_flow_controller u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .id_jump(id_jump), .id_jr(id_jr), .id_branch(id_branch),
    .id_ta(id_ta), .id_rs_val(id_rs_val), .ex_ta(ex_ta),
    .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_z(ex_z), .ex_n(ex_n), .npc(npc),
    .pc_next(pc_next), .pc_load_target(ld), .flush_if(fi), .flush_id(fid),
    .branch_pending(pend), .ds_error(ds), .taken_cnt(tk), .nottaken_cnt(nt)
  );

  branch_flow_controller #(.CNT_W(2), .DS_EN(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .stall(stall),
    .id_jump(id_jump), .id_jr(id_jr), .id_branch(id_branch),
    .id_ta(id_ta), .id_rs_val(id_rs_val), .ex_ta(ex_ta),
    .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_z(ex_z), .ex_n(ex_n), .npc(npc),
    .pc_next(pc_next2), .pc_load_target(ld2), .flush_if(fi2), .flush_id(fid2),
    .branch_pending(pend2), .ds_error(ds2), .taken_cnt(tk2), .nottaken_cnt(nt2)
  );

  function automatic stim_t st(logic rst, logic stl, logic j, logic jr, logic br,
                               logic [5:0] op, logic [4:0] rt, logic z, logic n);
    stim_t s;
    s.rst = rst; s.stl = stl; s.j = j; s.jr = jr; s.br = br;
    s.op = op; s.rt = rt; s.z = z; s.n = n;
    return s;
  endfunction

  function automatic exp_t ex(logic [31:0] pc, logic l, logic f_if, logic f_id,
                              logic p, int t, int nn, logic d);
    exp_t e;
    e.pc = pc; e.ld = l; e.fi = f_if; e.fid = f_id; e.pend = p;
    e.tk = t; e.nt = nn; e.ds = d;
    e.chk2 = 1'b0; e.fi2 = 1'b0; e.fid2 = 1'b0; e.tk2 = 0;
    return e;
  endfunction

  function automatic exp_t ex2(exp_t e, logic f_if, logic f_id, int t);
    exp_t r;
    r = e;
    r.chk2 = 1'b1; r.fi2 = f_if; r.fid2 = f_id; r.tk2 = t;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus just after the edge, queue its expectation,
  // then pop and compare mid-cycle while the inputs are stable.
  task automatic step(input string tag, input stim_t s, input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = s.rst; stall = s.stl;
    id_jump = s.j; id_jr = s.jr; id_branch = s.br;
    ex_opcode = s.op; ex_rt = s.rt; ex_z = s.z; ex_n = s.n;
    sb.push_back(e);
    #3;
    x = sb.pop_front();
    chk({tag, ".pc_next"},  pc_next, x.pc);
    chk({tag, ".load"},     {31'd0, ld},   {31'd0, x.ld});
    chk({tag, ".flush_if"}, {31'd0, fi},   {31'd0, x.fi});
    chk({tag, ".flush_id"}, {31'd0, fid},  {31'd0, x.fid});
    chk({tag, ".pending"},  {31'd0, pend}, {31'd0, x.pend});
    chk({tag, ".ds_error"}, {31'd0, ds},   {31'd0, x.ds});
    chk({tag, ".taken"},    {16'd0, tk},   x.tk);
    chk({tag, ".nottaken"}, {16'd0, nt},   x.nt);
    if (x.chk2) begin
      chk({tag, ".u2_flush_if"}, {31'd0, fi2},  {31'd0, x.fi2});
      chk({tag, ".u2_flush_id"}, {31'd0, fid2}, {31'd0, x.fid2});
      chk({tag, ".u2_taken"},    {30'd0, tk2},  x.tk2);
    end
  endtask

  initial begin
    logic [31:0] N;
    N = 32'h0040_0008;

    step("rst0", st(1,0,0,0,0,6'd0,5'd0,0,0), ex(N,0,0,0,0,0,0,0));
    step("rst1", st(1,0,0,0,0,6'd0,5'd0,0,0), ex2(ex(N,0,0,0,0,0,0,0),0,0,0));

    id_ta = 32'h0040_0100;
    step("j_idle", st(0,0,1,0,0,6'd0,5'd0,0,0),
         ex2(ex(32'h0040_0100,1,0,0,0,0,0,0),1,0,0));
    step("beq_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex(N,0,0,0,0,0,0,0));
    ex_ta = 32'h0000_0040;
    step("beq_ex", st(0,0,0,0,0,OP_BEQ,5'd0,1,0),
         ex2(ex(32'h40,1,1,0,1,0,0,0),1,1,0));

    step("bgtz_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex2(ex(N,0,0,0,0,1,0,0),0,0,1));
    step("bgtz_ex", st(0,0,0,0,0,OP_BGTZ,5'd0,0,1), ex(N,0,0,0,1,1,0,0));
    step("bgez_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex(N,0,0,0,0,1,1,0));
    ex_ta = 32'h0000_0100;
    step("bgez_ex", st(0,0,0,0,0,OP_REGIMM,RT_BGEZ,0,0), ex(32'h100,1,1,0,1,1,1,0));

    step("bne_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex(N,0,0,0,0,2,1,0));
    ex_ta = 32'h0000_0200;
    for (int i = 0; i < 3; i++)
      step("bne_stall", st(0,1,0,0,0,OP_BNE,5'd0,0,0), ex(N,0,0,0,1,2,1,0));
    step("bne_ex", st(0,0,0,0,0,OP_BNE,5'd0,0,0), ex(32'h200,1,1,0,1,2,1,0));

    id_rs_val = 32'h0000_1234;
    step("jr_idle", st(0,0,0,1,0,6'd0,5'd0,0,0), ex(32'h1234,1,0,0,0,3,1,0));
    step("prio", st(0,0,1,1,1,6'd0,5'd0,0,0), ex(32'h0040_0100,1,0,0,0,3,1,0));
    step("prio_nopend", st(0,0,0,0,0,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,1,0));
    step("idle_stall", st(0,1,1,0,0,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,1,0));

    step("blez_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,1,0));
    step("blez_slot_j", st(0,0,1,0,0,OP_BLEZ,5'd0,0,0), ex(N,0,0,0,1,3,1,0));
    step("ds_set", st(0,0,0,0,0,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,2,1));
    step("ds_sticky", st(0,0,0,0,0,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,2,1));

    step("rstp_id", st(0,0,0,0,1,6'd0,5'd0,0,0), ex(N,0,0,0,0,3,2,1));
    step("rst_in_pend", st(1,0,0,0,0,OP_BEQ,5'd0,1,0), ex(N,0,0,0,1,3,2,1));
    step("after_rst", st(0,0,0,0,0,6'd0,5'd0,0,0), ex2(ex(N,0,0,0,0,0,0,0),0,0,0));

    ex_ta = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      step("sat_id", st(0,0,0,0,1,6'd0,5'd0,0,0),
           ex2(ex(N,0,0,0,0,k,0,0),0,0,(k > 3) ? 3 : k));
      step("sat_ex", st(0,0,0,0,0,OP_BEQ,5'd0,1,0),
           ex2(ex(32'h80,1,1,0,1,k,0,0),1,1,(k > 3) ? 3 : k));
    end
    step("sat_end", st(0,0,0,0,0,6'd0,5'd0,0,0), ex2(ex(N,0,0,0,0,4,0,0),0,0,3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
